// File: rtl/maxpool_fifo.sv
// maxpool_fifo
//   Streaming max-pool over windows of Pool_size signed words, followed by a
//   first-word fall-through output FIFO of Depth entries.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     Clear      synchronous flush of the pooling window and the FIFO
//     In_valid   In_data is valid this cycle
//     In_data    signed input word
//     In_last    accepted word closes the current window early
//     In_ready   block can accept a word this cycle (FIFO not full)
//     Out_valid  Out_data holds a pooled result (FIFO not empty)
//     Out_data   oldest pooled result, presented combinationally
//     Out_ready  consumer takes Out_data this cycle
//     Count      current FIFO occupancy
module maxpool_fifo #(
    parameter int Bit_width = 32,
    parameter int Pool_size = 2,
    parameter int Depth     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        Clear,
    input  logic                        In_valid,
    input  logic signed [Bit_width-1:0] In_data,
    input  logic                        In_last,
    output logic                        In_ready,
    output logic                        Out_valid,
    output logic signed [Bit_width-1:0] Out_data,
    input  logic                        Out_ready,
    output logic [$clog2(Depth):0]      Count
);

    localparam int AW   = $clog2(Depth);
    localparam int CNTW = AW + 1;
    localparam int CW   = (Pool_size > 1) ? $clog2(Pool_size) : 1;
    localparam logic [CW-1:0] WIN_LAST = CW'(Pool_size - 1);

    // Signed maximum; on a tie the current (first) operand is kept.
    function automatic logic signed [Bit_width-1:0] max_s(
        input logic signed [Bit_width-1:0] cur,
        input logic signed [Bit_width-1:0] nxt
    );
        return (nxt > cur) ? nxt : cur;
    endfunction

    logic [CW-1:0]                win_cnt_p0;
    logic signed [Bit_width-1:0]  run_max_p0;
    logic signed [Bit_width-1:0]  max_p0;
    logic                         accept_p0;
    logic                         vld_p0;

    logic signed [Bit_width-1:0]  mem_p1 [Depth];
    logic [AW-1:0]                wr_ptr_p1;
    logic [AW-1:0]                rd_ptr_p1;
    logic [CNTW-1:0]              count_p1;
    logic                         full_p1;
    logic                         pop_p1;

    // ---- Stage p0: window accumulation ----
    assign full_p1   = (count_p1 == CNTW'(Depth));
    assign In_ready  = !full_p1;
    assign accept_p0 = In_valid && In_ready;

    // First word of a window stands alone; later words fold into the running max.
    assign max_p0 = (win_cnt_p0 == '0) ? In_data : max_s(run_max_p0, In_data);
    assign vld_p0 = accept_p0 && ((win_cnt_p0 == WIN_LAST) || In_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_p0 <= '0;
            run_max_p0 <= '0;
        end else if (Clear) begin
            win_cnt_p0 <= '0;
            run_max_p0 <= '0;
        end else if (accept_p0) begin
            run_max_p0 <= max_p0;
            if (vld_p0)
                win_cnt_p0 <= '0;
            else
                win_cnt_p0 <= win_cnt_p0 + CW'(1);
        end
    end

    // ---- Stage p1: output FIFO ----
    assign Out_valid = (count_p1 != '0);
    assign pop_p1    = Out_valid && Out_ready;
    assign Out_data  = mem_p1[rd_ptr_p1];
    assign Count     = count_p1;

    // Storage carries data only; occupancy and pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (vld_p0 && !Clear)
            mem_p1[wr_ptr_p1] <= max_p0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
        end else if (Clear) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
        end else begin
            if (vld_p0)
                wr_ptr_p1 <= wr_ptr_p1 + AW'(1);
            if (pop_p1)
                rd_ptr_p1 <= rd_ptr_p1 + AW'(1);
            if (vld_p0 && !pop_p1)
                count_p1 <= count_p1 + CNTW'(1);
            else if (pop_p1 && !vld_p0)
                count_p1 <= count_p1 - CNTW'(1);
        end
    end

endmodule

// File: tb/tb_maxpool_fifo.sv
module tb_maxpool_fifo;

    localparam int BW = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 Clear;
    logic                 In_valid;
    logic signed [BW-1:0] In_data;
    logic                 In_last;
    logic                 In_ready;
    logic                 Out_valid;
    logic signed [BW-1:0] Out_data;
    logic                 Out_ready;
    logic [3:0]           Count;

    int checks = 0;
    int errors = 0;

    maxpool_fifo #(.Bit_width(BW), .Pool_size(2), .Depth(8)) dut (
        .clk(clk), .rst_n(rst_n), .Clear(Clear),
        .In_valid(In_valid), .In_data(In_data), .In_last(In_last),
        .In_ready(In_ready), .Out_valid(Out_valid), .Out_data(Out_data),
        .Out_ready(Out_ready), .Count(Count)
    );

    always #5 clk = ~clk;

    // One clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic signed [BW-1:0] d, input logic last);
        In_valid = 1'b1;
        In_data  = d;
        In_last  = last;
        tick();
        In_valid = 1'b0;
        In_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Clear = 1'b0; In_valid = 1'b0; In_data = '0;
        In_last = 1'b0; Out_ready = 1'b0;
        #12;
        checks++; if (Count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", Count); end
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", Out_valid); end
        checks++; if (In_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", In_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        Out_ready = 1'b1;
        In_valid = 1'b1; In_last = 1'b0;
        In_data = 5; tick();
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL basic_first_word: got valid %b expected 0", Out_valid); end
        In_data = -3; tick();
        checks++; if (Out_valid !== 1'b1 || Out_data !== 5) begin errors++; $display("FAIL basic_out5: got valid %b data %0d expected 1/5", Out_valid, Out_data); end
        In_data = 7; tick();
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got valid %b expected 0", Out_valid); end
        In_data = 9; tick();
        checks++; if (Out_valid !== 1'b1 || Out_data !== 9) begin errors++; $display("FAIL basic_out9: got valid %b data %0d expected 1/9", Out_valid, Out_data); end
        In_valid = 1'b0; tick();
        checks++; if (Count !== 4'd0 || Out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got count %0d valid %b expected 0/0", Count, Out_valid); end
    endtask

    task automatic test_signed();
        Out_ready = 1'b1;
        put(-8, 1'b0);
        put(-2, 1'b0);
        checks++; if (Out_valid !== 1'b1 || Out_data !== -2) begin errors++; $display("FAIL signed_neg: got %0d expected -2", Out_data); end
        put(32'sh7FFFFFFF, 1'b0);
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL signed_pop: got valid %b expected 0", Out_valid); end
        put(32'sh80000000, 1'b0);
        checks++; if (Out_data !== 32'sh7FFFFFFF) begin errors++; $display("FAIL signed_extreme: got %h expected 7fffffff", Out_data); end
        tick();
        put(3, 1'b0);
        put(3, 1'b0);
        checks++; if (Out_data !== 3) begin errors++; $display("FAIL signed_tie: got %0d expected 3", Out_data); end
        tick();
    endtask

    task automatic test_last();
        Out_ready = 1'b1;
        put(4, 1'b1);
        checks++; if (Out_valid !== 1'b1 || Out_data !== 4) begin errors++; $display("FAIL last_single: got valid %b data %0d expected 1/4", Out_valid, Out_data); end
        put(1, 1'b0);
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL last_counter_reset: got valid %b expected 0", Out_valid); end
        put(2, 1'b0);
        checks++; if (Out_data !== 2) begin errors++; $display("FAIL last_next_pair: got %0d expected 2", Out_data); end
        tick();
    endtask

    task automatic test_fill();
        logic signed [BW-1:0] exp_q [$];
        logic signed [BW-1:0] a, b;
        Out_ready = 1'b0;
        // Offset the pointers so the fill wraps.
        for (int k = 0; k < 3; k++) begin put(k, 1'b0); put(k + 50, 1'b0); end
        Out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (Out_data !== k + 50) begin errors++; $display("FAIL fill_pre_%0d: got %0d expected %0d", k, Out_data, k + 50); end
            tick();
        end
        Out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            a = 100 + k;
            b = (k % 2 == 1) ? 200 + k : -k;
            if (k < 8) exp_q.push_back((k % 2 == 1) ? b : a);
            put(a, 1'b0);
            put(b, 1'b0);
        end
        checks++; if (Count !== 4'd8 || In_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got count %0d ready %b expected 8/0", Count, In_ready); end
        Out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (Out_valid !== 1'b1 || Out_data !== exp_q[k]) begin errors++; $display("FAIL fill_drain_%0d: got %0d expected %0d", k, Out_data, exp_q[k]); end
            tick();
        end
        checks++; if (Count !== 4'd0) begin errors++; $display("FAIL fill_empty: got %0d expected 0", Count); end
        Out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin put(-1000 - k, 1'b0); put(-2000, 1'b0); end
        checks++; if (Count !== 4'd8) begin errors++; $display("FAIL fill2_full: got %0d expected 8", Count); end
        Out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (Out_data !== -1000 - k) begin errors++; $display("FAIL fill2_drain_%0d: got %0d expected %0d", k, Out_data, -1000 - k); end
            tick();
        end
        Out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        Out_ready = 1'b0;
        put(1, 1'b0); put(12, 1'b0);
        put(30, 1'b0); put(2, 1'b0);
        put(5, 1'b0); put(5, 1'b0);
        put(40, 1'b0);
        checks++; if (Count !== 4'd3) begin errors++; $display("FAIL b2b_count3: got %0d expected 3", Count); end
        Out_ready = 1'b1;
        put(41, 1'b0);
        checks++; if (Count !== 4'd3 || Out_data !== 30) begin errors++; $display("FAIL b2b_simul: got count %0d data %0d expected 3/30", Count, Out_data); end
        tick();
        checks++; if (Out_data !== 5) begin errors++; $display("FAIL b2b_order5: got %0d expected 5", Out_data); end
        tick();
        checks++; if (Out_data !== 41) begin errors++; $display("FAIL b2b_order41: got %0d expected 41", Out_data); end
        tick();
        Out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin put(k, 1'b0); put(k, 1'b0); end
        Out_ready = 1'b1;
        In_valid = 1'b1; In_data = 999;
        #1;
        checks++; if (In_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_pop_ready: got %b expected 0", In_ready); end
        tick();
        In_valid = 1'b0;
        checks++; if (In_ready !== 1'b1 || Count !== 4'd7) begin errors++; $display("FAIL b2b_after_pop: got ready %b count %0d expected 1/7", In_ready, Count); end
        for (int k = 0; k < 7; k++) tick();
        put(77, 1'b1);
        checks++; if (Out_data !== 77) begin errors++; $display("FAIL b2b_not_accepted: got %0d expected 77", Out_data); end
        tick();
        Out_ready = 1'b0;
    endtask

    task automatic test_clear();
        Out_ready = 1'b0;
        put(10, 1'b0); put(11, 1'b0);
        put(20, 1'b0); put(21, 1'b0);
        put(50, 1'b0);
        checks++; if (Count !== 4'd2) begin errors++; $display("FAIL clear_pre: got %0d expected 2", Count); end
        Clear = 1'b1; Out_ready = 1'b1;
        put(60, 1'b0);
        Clear = 1'b0; Out_ready = 1'b0;
        checks++; if (Count !== 4'd0 || Out_valid !== 1'b0) begin errors++; $display("FAIL clear_flush: got count %0d valid %b expected 0/0", Count, Out_valid); end
        put(6, 1'b0); put(1, 1'b0);
        checks++; if (Count !== 4'd1 || Out_data !== 6) begin errors++; $display("FAIL clear_next_pair: got count %0d data %0d expected 1/6", Count, Out_data); end
        Out_ready = 1'b1; tick(); Out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        Out_ready = 1'b0;
        put(3, 1'b0); put(4, 1'b0);
        put(100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (Count !== 4'd0 || Out_valid !== 1'b0 || In_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got count %0d valid %b ready %b expected 0/0/1", Count, Out_valid, In_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        put(1, 1'b0);
        checks++; if (Count !== 4'd0) begin errors++; $display("FAIL async_first_word: got count %0d expected 0", Count); end
        put(2, 1'b0);
        checks++; if (Count !== 4'd1 || Out_data !== 2) begin errors++; $display("FAIL async_pair: got count %0d data %0d expected 1/2", Count, Out_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_last();
        test_fill();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_fifo.md
MAXPOOL_FIFO -- requirements
Module: maxpool_fifo

Interface
REQ-001 SHALL have parameter Bit_width, default 32; width of each signed data word.
REQ-002 SHALL have parameter Pool_size, default 2, legal range 2..8; number of accepted inputs per pooling window.
REQ-003 SHALL have parameter Depth, default 8, power of two, minimum 2; number of output FIFO entries.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1 bit; reset, asynchronous and active-low.
REQ-006 SHALL have port Clear, input, 1 bit; synchronous flush of the window and the FIFO.
REQ-007 SHALL have port In_valid, input, 1 bit; In_data is valid this cycle.
REQ-008 SHALL have port In_data, input, Bit_width bits, signed; post-adder/ReLU result word.
REQ-009 SHALL have port In_last, input, 1 bit; the accepted word closes the current window early (end of channel).
REQ-010 SHALL have port In_ready, output, 1 bit; block can accept a word this cycle.
REQ-011 SHALL have port Out_valid, output, 1 bit; Out_data holds a pooled result.
REQ-012 SHALL have port Out_data, output, Bit_width bits, signed; oldest pooled result.
REQ-013 SHALL have port Out_ready, input, 1 bit; consumer takes Out_data this cycle.
REQ-014 SHALL have port Count, output, clog2(Depth)+1 bits; current FIFO occupancy.

Function
REQ-015 SHALL define accept as In_valid && In_ready, and pop as Out_valid && Out_ready.
REQ-016 SHALL drive In_ready = !full, where full means Count == Depth; a pop in the same cycle SHALL NOT raise In_ready.
REQ-017 SHALL keep a window counter 0..Pool_size-1 and a running-max register.
REQ-018 On accept with counter == 0, the running max SHALL load In_data.
REQ-019 On accept with counter > 0, the running max SHALL become the signed maximum of itself and In_data; on a tie it keeps its current value.
REQ-020 A window SHALL complete on accept when counter == Pool_size-1 or In_last == 1.
REQ-021 On window completion the block SHALL push max(running max, In_data) into the FIFO (or In_data alone if counter == 0), and SHALL reset the counter to 0.
REQ-022 On a non-completing accept the counter SHALL increment by 1.
REQ-023 No accept SHALL leave the counter and running max unchanged.
REQ-024 Out_valid SHALL assert exactly when Count > 0.
REQ-025 Out_data SHALL present the head entry combinationally from the FIFO storage (first-word fall-through).
REQ-026 Latency SHALL be 1 cycle: Out_valid rises on the clock edge after a completing accept into an empty FIFO.
REQ-027 Push and pop in the same cycle SHALL leave Count unchanged and preserve order.
REQ-028 Read and write pointers SHALL be clog2(Depth) bits and SHALL wrap from Depth-1 to 0.
REQ-029 A pop with Out_valid == 0 SHALL be ignored; pointers SHALL NOT move.
REQ-030 Clear SHALL take priority over accept and pop in the same cycle: the counter, running max, pointers and Count SHALL go to 0, and the in-flight word SHALL be discarded.
REQ-031 Arithmetic SHALL be signed two's complement at Bit_width with no saturation; the FIFO SHALL store values unmodified.

Reset
REQ-032 Asserting rst_n low SHALL immediately force Count=0, Out_valid=0, In_ready=1, window counter=0, running max=0, pointers=0; Out_data is don't-care while the FIFO is empty.
REQ-033 Reset asserted mid-window or with the FIFO non-empty SHALL discard all partial and stored results.
REQ-034 The first accept after rst_n deasserts SHALL be treated as counter == 0.

Verification
REQ-035 Pool_size=2: accept 5, -3, 7, 9 with Out_ready=1 -> outputs 5 then 9, each with Out_valid one cycle after the pair completes.
REQ-036 Accept -8, -2 -> output -2 (signed compare); accept 0x7FFFFFFF, 0x80000000 -> output 0x7FFFFFFF.
REQ-037 Accept 4 with In_last=1 -> output 4, counter back to 0; next pair 1, 2 -> output 2.
REQ-038 Depth=8, Out_ready=0, feed 16 pairs -> Count saturates at 8 with In_ready=0; then drain 8 outputs in push order, with pointers wrapping correctly across a second fill.
REQ-039 With Count=3, do a simultaneous completing accept and pop -> Count stays 3 and order is preserved; with Count=8 and a pop -> In_ready is 0 that cycle and 1 the next.
REQ-040 Assert Clear after one word of a pair, with Count=2 -> Count=0 and Out_valid=0 next cycle; the next pair 6, 1 -> output 6.
